// File: rtl/seq_gen_pkg.sv
// Shared types for the serial pattern generator that feeds the sequence detector.
// State encoding and the default pattern width live here.
package seq_gen_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/seq_gen_shreg.sv
// Shift register and bit counter for seq_gen_tx.
// msb is the bit to drive on w after this edge; last marks the final bit on w.
module seq_gen_shreg
   import seq_gen_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load,
   input  logic                       shift,
   input  logic [WIDTH-1:0]           data,
   input  logic [$clog2(WIDTH+1)-1:0] len,
   output logic                       msb,
   output logic                       last
);

   localparam int LW = $clog2(WIDTH+1);

   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] aligned;
   logic [LW-1:0]    cnt;
   logic [LW-1:0]    len_c;

   always_comb begin
      len_c   = (len > LW'(WIDTH)) ? LW'(WIDTH) : len;
      aligned = data << (LW'(WIDTH) - len_c);
   end

   // sr holds only the bits still to come; the current bit already sits on w
   assign msb  = load ? aligned[WIDTH-1] : sr[WIDTH-1];
   assign last = (cnt == LW'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr  <= '0;
         cnt <= '0;
      end else if (load) begin
         sr  <= aligned << 1;
         cnt <= len_c;
      end else if (shift) begin
         sr  <= sr << 1;
         cnt <= cnt - LW'(1);
      end
   end

endmodule

// File: rtl/seq_gen_tx.sv
// Moore FSM that serialises a Len-bit pattern MSB-first onto w.
// Optional continuous looping is enabled by defining SEQ_GEN_TX_REPEAT_EN.
module seq_gen_tx
   import seq_gen_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                       Clock,
   input  logic                       Reset,
   input  logic                       Start,
   input  logic [WIDTH-1:0]           Pattern,
   input  logic [$clog2(WIDTH+1)-1:0] Len,
   input  logic                       Repeat,
   output logic                       w,
   output logic                       Busy,
   output logic                       Done
);

   localparam int LW = $clog2(WIDTH+1);

   state_t           state;
   logic             accept;
   logic             again;
   logic             load;
   logic             shift;
   logic             msb;
   logic             last;
   logic [WIDTH-1:0] sh_data;
   logic [LW-1:0]    sh_len;

   assign accept = (state == IDLE) && Start && (Len != '0);

`ifdef SEQ_GEN_TX_REPEAT_EN
   logic [WIDTH-1:0] pat_q;
   logic [LW-1:0]    len_q;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         pat_q <= '0;
         len_q <= '0;
      end else if (accept) begin
         pat_q <= Pattern;
         len_q <= Len;
      end
   end

   assign again   = (state == SHIFT) && last && Repeat;
   assign sh_data = (state == IDLE) ? Pattern : pat_q;
   assign sh_len  = (state == IDLE) ? Len : len_q;
`else
   logic unused_repeat;

   assign unused_repeat = Repeat;
   assign again         = 1'b0;
   assign sh_data       = Pattern;
   assign sh_len        = Len;
`endif

   assign load  = accept || again;
   assign shift = (state == SHIFT) && !again;

   seq_gen_shreg #(
      .WIDTH(WIDTH)
   ) u_shreg (
      .clk  (Clock),
      .rst  (Reset),
      .load (load),
      .shift(shift),
      .data (sh_data),
      .len  (sh_len),
      .msb  (msb),
      .last (last)
   );

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         w     <= 1'b0;
         Busy  <= 1'b0;
         Done  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  state <= SHIFT;
                  w     <= msb;
                  Busy  <= 1'b1;
               end
            end
            SHIFT: begin
               if (last && !again) begin
                  state <= DONE;
                  w     <= 1'b0;
                  Busy  <= 1'b0;
                  Done  <= 1'b1;
               end else begin
                  w <= msb;
               end
            end
            DONE: begin
               state <= IDLE;
               Done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               w     <= 1'b0;
               Busy  <= 1'b0;
               Done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_gen_tx.sv
// Self-checking bench for seq_gen_tx: vector table, corner sequences,
// and random traffic against a queue-based model of the serial stream.
module tb_seq_gen_tx;

   localparam int WIDTH = 8;
   localparam int LW    = $clog2(WIDTH+1);

   logic             Clock = 1'b0;
   logic             Reset;
   logic             Start;
   logic [WIDTH-1:0] Pattern;
   logic [LW-1:0]    Len;
   logic             Repeat;
   logic             w;
   logic             Busy;
   logic             Done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string            name;
      logic             start;
      logic [WIDTH-1:0] pattern;
      logic [LW-1:0]    len;
      logic [2:0]       exp;
   } vec_t;

   vec_t       tbl[$];
   logic [2:0] mq[$];
   logic [2:0] mout;
   bit         prev_done;
   int         done_cnt;

   always #5 Clock = ~Clock;

   seq_gen_tx #(
      .WIDTH(WIDTH)
   ) dut (
      .Clock  (Clock),
      .Reset  (Reset),
      .Start  (Start),
      .Pattern(Pattern),
      .Len    (Len),
      .Repeat (Repeat),
      .w      (w),
      .Busy   (Busy),
      .Done   (Done)
   );

   function automatic void add(string n, logic s, logic [WIDTH-1:0] p,
                               logic [LW-1:0] l, logic [2:0] e);
      vec_t v;
      v.name    = n;
      v.start   = s;
      v.pattern = p;
      v.len     = l;
      v.exp     = e;
      tbl.push_back(v);
   endfunction

   task automatic check(string n, logic [2:0] e);
      checks++;
      if ({w, Busy, Done} !== e) begin
         errors++;
         $display("FAIL %s t=%0t: w/busy/done=%b required %b",
                  n, $time, {w, Busy, Done}, e);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Reference: a pass is Len bits MSB-first then one Done cycle;
   // a new pass can only start once the stream and the Done cycle are over.
   task automatic model_edge();
      int l;
      if (mq.size() == 0 && !prev_done && Start && Len != '0) begin
         l = (int'(Len) > WIDTH) ? WIDTH : int'(Len);
         for (int i = l - 1; i >= 0; i--)
            mq.push_back({Pattern[i], 2'b10});
         mq.push_back(3'b001);
      end
      mout      = (mq.size() != 0) ? mq.pop_front() : 3'b000;
      prev_done = mout[0];
   endtask

   initial begin
      logic [7:0] bits;

      add("p07", 1, 8'h07, 3, 3'b110);
      add("p07", 0, 8'h00, 0, 3'b110);
      add("p07", 0, 8'h00, 0, 3'b110);
      add("p07", 0, 8'h00, 0, 3'b001);
      add("p07", 0, 8'h00, 0, 3'b000);
      bits = 8'hAD;
      add("pAD", 1, 8'hAD, 8, {bits[7], 2'b10});
      for (int i = 6; i >= 0; i--)
         add("pAD", 0, 8'hFF, 8, {bits[i], 2'b10});
      add("pAD", 0, 8'hFF, 8, 3'b001);
      add("pAD", 0, 8'hFF, 8, 3'b000);
      for (int i = 0; i < 5; i++)
         add("len0", 1, 8'hFF, 0, 3'b000);
      bits = 8'hC1;
      add("clamp", 1, 8'hC1, 15, {bits[7], 2'b10});
      for (int i = 6; i >= 0; i--)
         add("clamp", 0, 8'h00, 0, {bits[i], 2'b10});
      add("clamp", 0, 8'h00, 0, 3'b001);
      add("clamp", 0, 8'h00, 0, 3'b000);
      add("len1", 1, 8'h01, 1, 3'b110);
      add("len1", 0, 8'h00, 0, 3'b001);
      add("len1", 0, 8'h00, 0, 3'b000);
      add("held", 1, 8'h03, 2, 3'b110);
      add("held", 1, 8'h03, 2, 3'b110);
      add("held", 1, 8'h03, 2, 3'b001);
      add("held", 1, 8'h03, 2, 3'b000);
      add("held", 1, 8'h03, 2, 3'b110);
      add("held", 1, 8'h03, 2, 3'b110);
      add("held", 0, 8'h03, 2, 3'b001);
      add("held", 0, 8'h03, 2, 3'b000);

      Reset   = 1'b1;
      Start   = 1'b0;
      Pattern = '0;
      Len     = '0;
      Repeat  = 1'b0;
      #1;
      check("reset", 3'b000);
      #6;
      Reset = 1'b0;

      foreach (tbl[k]) begin
         Start   = tbl[k].start;
         Pattern = tbl[k].pattern;
         Len     = tbl[k].len;
         tick();
         check(tbl[k].name, tbl[k].exp);
      end

      // Start/Pattern/Len disturbed during the 3rd bit must not alter the pass
      bits     = 8'hAD;
      done_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         Start   = (i == 0 || i == 3);
         Pattern = (i == 0) ? 8'hAD : 8'h00;
         Len     = (i == 0) ? 4'd8 : 4'd3;
         tick();
         check("ignore", {bits[7-i], 2'b10});
      end
      Start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (Done) done_cnt++;
      end
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL ignore_done: pulses=%0d required 1", done_cnt);
      end

      // Asynchronous reset during bit 4 aborts the pass
      for (int i = 0; i < 4; i++) begin
         Start   = (i == 0);
         Pattern = 8'hFF;
         Len     = 4'd8;
         tick();
         check("pre_rst", 3'b110);
      end
      #2;
      Reset = 1'b1;
      #1;
      check("rst_async", 3'b000);
      #2;
      Reset    = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (Done) done_cnt++;
         check("post_rst", 3'b000);
      end
      checks++;
      if (done_cnt != 0) begin
         errors++;
         $display("FAIL rst_done: pulses=%0d required 0", done_cnt);
      end

`ifdef SEQ_GEN_TX_REPEAT_EN
      Repeat   = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 7; i++) begin
         Start   = (i == 0);
         Pattern = 8'h02;
         Len     = 4'd2;
         tick();
         check("repeat", {(i % 2 == 0), 2'b10});
      end
      Repeat = 1'b0;
      tick();
      check("rep_end", 3'b010);
      tick();
      check("rep_end", 3'b001);
      tick();
      check("rep_end", 3'b000);
`else
      Repeat = 1'b1;
      Start  = 1'b1;
      Pattern = 8'h02;
      Len     = 4'd2;
      tick();
      check("no_repeat", 3'b110);
      Start = 1'b0;
      tick();
      check("no_repeat", 3'b010);
      tick();
      check("no_repeat", 3'b001);
      tick();
      check("no_repeat", 3'b000);
      Repeat = 1'b0;
`endif

      mq.delete();
      prev_done = 1'b0;
      Repeat    = 1'b0;
      for (int i = 0; i < 400; i++) begin
         Start   = ($urandom_range(0, 2) == 0);
         Pattern = WIDTH'($urandom);
         Len     = LW'($urandom_range(0, 15));
         model_edge();
         tick();
         check("random", mout);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
